ofs_plat_host_chan_fiu_if_tie_off_mmio: RTL and testbench

Parametrised, active tie-off for one or more CCI-P host channel ports that have no AFU attached. Every TX request channel is held idle. Every MMIO read still gets a well-formed response, so host software never hits an MMIO timeout, and a DFH read at offset 0 returns a null, end-of-list header. Stray traffic is counted per port for debug. The block sits at the platform edge, in place of an AFU on unused host channel ports.

---
 rtl/ofs_plat_host_chan_tie_off_pkg.sv | 95 +++++++++
 rtl/ofs_plat_host_ccip_if.sv | 13 +
 rtl/ofs_plat_host_chan_tie_off_mmio_port.sv | 96 +++++++++
 rtl/ofs_plat_host_chan_fiu_if_tie_off_mmio.sv | 54 +++++
 tb/tb_ofs_plat_host_chan_fiu_if_tie_off_mmio.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofs_plat_host_chan_tie_off_pkg.sv
// ofs_plat_host_chan_tie_off_pkg
// Shared types and helpers for the CCI-P host channel MMIO tie-off.
// Holds the trimmed CCI-P channel structs carried by ofs_plat_host_ccip_if,
// the MMIO read pipeline entry, the default null/EOL DFH and the
// saturating counter helper.
package ofs_plat_host_chan_tie_off_pkg;

  localparam int CCIP_CLDATA_W = 512;
  localparam int MMIO_DATA_W   = 64;
  localparam int MMIO_TID_W    = 9;
  localparam int MMIO_ADDR_W   = 16;
  localparam int CNT_MAX_W     = 64;

  // CCI-P MMIO request length encoding
  localparam logic [1:0] MMIO_LEN_4B  = 2'b00;
  localparam logic [1:0] MMIO_LEN_8B  = 2'b01;
  localparam logic [1:0] MMIO_LEN_64B = 2'b10;

  // Feature type AFU, EOL set, no next DFH: a null end-of-list header
  localparam logic [63:0] DFH_NULL_EOL = 64'h1000_0100_0000_0000;

  typedef struct packed {
    logic [MMIO_ADDR_W-1:0] address;  // 4-byte units
    logic [1:0]             length;
    logic                   rsvd;
    logic [MMIO_TID_W-1:0]  tid;
  } t_ccip_c0_req_mmio_hdr;

  typedef struct packed {
    logic [MMIO_TID_W-1:0] tid;
  } t_ccip_c2_rsp_mmio_hdr;

  typedef struct packed {
    t_ccip_c0_req_mmio_hdr    hdr;
    logic [CCIP_CLDATA_W-1:0] data;
    logic                     rspValid;
    logic                     mmioRdValid;
    logic                     mmioWrValid;
  } t_if_ccip_c0_rx;

  typedef struct packed {
    logic [27:0] hdr;
    logic        rspValid;
  } t_if_ccip_c1_rx;

  typedef struct packed {
    t_if_ccip_c0_rx c0;
    t_if_ccip_c1_rx c1;
  } t_if_ccip_rx;

  typedef struct packed {
    logic [73:0] hdr;
    logic        valid;
  } t_if_ccip_c0_tx;

  typedef struct packed {
    logic [79:0]              hdr;
    logic [CCIP_CLDATA_W-1:0] data;
    logic                     valid;
  } t_if_ccip_c1_tx;

  typedef struct packed {
    t_ccip_c2_rsp_mmio_hdr  hdr;
    logic                   mmioRdValid;
    logic [MMIO_DATA_W-1:0] data;
  } t_if_ccip_c2_tx;

  typedef struct packed {
    t_if_ccip_c0_tx c0;
    t_if_ccip_c1_tx c1;
    t_if_ccip_c2_tx c2;
  } t_if_ccip_tx;

  // One in-flight MMIO read; len=1 means an 8-byte access
  typedef struct packed {
    logic                   valid;
    logic [MMIO_TID_W-1:0]  tid;
    logic [MMIO_ADDR_W-1:0] addr;
    logic                   len;
  } t_mmio_rd_pipe;

  // value + amount, clamped to the all-ones value of a width-bit counter
  function automatic logic [CNT_MAX_W-1:0] sat_inc(
    input logic [CNT_MAX_W-1:0] value,
    input logic [1:0]           amount,
    input int unsigned          width
  );
    logic [CNT_MAX_W:0] lim;
    logic [CNT_MAX_W:0] sum;
    lim = ((CNT_MAX_W+1)'(1) << width) - (CNT_MAX_W+1)'(1);
    sum = {1'b0, value} + {{(CNT_MAX_W-1){1'b0}}, amount};
    return (sum > lim) ? lim[CNT_MAX_W-1:0] : sum[CNT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/ofs_plat_host_ccip_if.sv
// ofs_plat_host_ccip_if
// One CCI-P host channel: sTx toward the FIU, sRx from the FIU.
//   to_fiu : AFU-side view (drives sTx, receives sRx)
//   to_afu : FIU-side view (drives sRx, receives sTx)
interface ofs_plat_host_ccip_if;
  import ofs_plat_host_chan_tie_off_pkg::*;

  t_if_ccip_tx sTx;
  t_if_ccip_rx sRx;

  modport to_fiu (output sTx, input sRx);
  modport to_afu (input sTx, output sRx);
endinterface

// File: rtl/ofs_plat_host_chan_tie_off_mmio_port.sv
// ofs_plat_host_chan_tie_off_mmio_port
// Tie-off for a single CCI-P port: TX request channels idle, every MMIO
// read answered after MMIO_RD_LATENCY cycles, writes dropped, stray
// responses counted.
//   clk, reset_n        : clock, async active-low reset
//   ccip                : host channel (to_fiu view)
//   mmio_rd_cnt         : reads answered (saturating)
//   mmio_wr_cnt         : writes discarded (saturating)
//   stray_rsp_cnt       : unexpected c0/c1 responses (saturating)
//   stray_rsp_seen      : sticky, set on the first stray response
module ofs_plat_host_chan_tie_off_mmio_port
  import ofs_plat_host_chan_tie_off_pkg::*;
#(
  parameter int          MMIO_RD_LATENCY = 4,
  parameter logic [63:0] DFH_VALUE       = DFH_NULL_EOL,
  parameter logic [63:0] MMIO_RD_DATA    = 64'h0,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ofs_plat_host_ccip_if.to_fiu  ccip,
  output logic [CNT_WIDTH-1:0]  mmio_rd_cnt,
  output logic [CNT_WIDTH-1:0]  mmio_wr_cnt,
  output logic [CNT_WIDTH-1:0]  stray_rsp_cnt,
  output logic                  stray_rsp_seen
);

  t_mmio_rd_pipe [MMIO_RD_LATENCY-1:0] rd_pipe;
  t_mmio_rd_pipe                       rd_in;
  t_mmio_rd_pipe                       rd_out;
  logic [63:0]                         rd_sel;
  logic [63:0]                         rd_data;
  logic [1:0]                          stray_amt;
  logic                                unused_rx;

  always_comb begin
    rd_in       = '0;
    rd_in.valid = ccip.sRx.c0.mmioRdValid;
    rd_in.tid   = ccip.sRx.c0.hdr.tid;
    rd_in.addr  = ccip.sRx.c0.hdr.address;
    // Anything other than a 4-byte request is answered as 8 bytes
    rd_in.len   = (ccip.sRx.c0.hdr.length != MMIO_LEN_4B);
  end

  // Fixed-latency shift pipeline; the response is driven straight off the
  // last stage so there is no RX->TX combinational path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_in;
      for (int s = 1; s < MMIO_RD_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
  end

  assign rd_out = rd_pipe[MMIO_RD_LATENCY-1];

  // Offsets 0-7 (dword addresses 0 and 1) hold the DFH
  always_comb begin
    rd_sel = (rd_out.addr[15:1] == '0) ? DFH_VALUE : MMIO_RD_DATA;
    if (rd_out.len)          rd_data = rd_sel;
    else if (rd_out.addr[0]) rd_data = {32'h0, rd_sel[63:32]};
    else                     rd_data = {32'h0, rd_sel[31:0]};
  end

  always_comb begin
    ccip.sTx                  = '0;
    ccip.sTx.c2.mmioRdValid   = rd_out.valid;
    ccip.sTx.c2.hdr.tid       = rd_out.tid;
    ccip.sTx.c2.data          = rd_data;
  end

  assign stray_amt = {1'b0, ccip.sRx.c0.rspValid} + {1'b0, ccip.sRx.c1.rspValid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mmio_rd_cnt    <= '0;
      mmio_wr_cnt    <= '0;
      stray_rsp_cnt  <= '0;
      stray_rsp_seen <= 1'b0;
    end else begin
      // Counted when the response leaves, not when the request arrives
      mmio_rd_cnt   <= CNT_WIDTH'(sat_inc(CNT_MAX_W'(mmio_rd_cnt),
                                          {1'b0, rd_out.valid}, CNT_WIDTH));
      mmio_wr_cnt   <= CNT_WIDTH'(sat_inc(CNT_MAX_W'(mmio_wr_cnt),
                                          {1'b0, ccip.sRx.c0.mmioWrValid}, CNT_WIDTH));
      stray_rsp_cnt <= CNT_WIDTH'(sat_inc(CNT_MAX_W'(stray_rsp_cnt),
                                          stray_amt, CNT_WIDTH));
      if (stray_amt != 2'd0) stray_rsp_seen <= 1'b1;
    end
  end

  // Write data, reserved bits and c1 headers carry nothing for a tie-off
  assign unused_rx = &{1'b0, ccip.sRx.c0.data, ccip.sRx.c0.hdr.rsvd, ccip.sRx.c1.hdr};

endmodule

// File: rtl/ofs_plat_host_chan_fiu_if_tie_off_mmio.sv
// ofs_plat_host_chan_fiu_if_tie_off_mmio
// Active tie-off for NUM_PORTS unused CCI-P host channel ports. Each port
// gets an independent ofs_plat_host_chan_tie_off_mmio_port; the per-port
// status counters are packed with port i at [i*CNT_WIDTH +: CNT_WIDTH].
//   clk, reset_n   : clock of every port[], async active-low reset
//   port[]         : tied-off host channels (to_fiu view)
//   mmio_rd_cnt    : MMIO reads answered, per port
//   mmio_wr_cnt    : MMIO writes discarded, per port
//   stray_rsp_cnt  : unexpected c0/c1 responses, per port
//   stray_rsp_seen : sticky stray-response flag, per port
module ofs_plat_host_chan_fiu_if_tie_off_mmio
  import ofs_plat_host_chan_tie_off_pkg::*;
#(
  parameter int          NUM_PORTS       = 1,
  parameter int          MMIO_RD_LATENCY = 4,
  parameter logic [63:0] DFH_VALUE       = DFH_NULL_EOL,
  parameter logic [63:0] MMIO_RD_DATA    = 64'h0,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  ofs_plat_host_ccip_if.to_fiu           port [NUM_PORTS],
  output logic [NUM_PORTS*CNT_WIDTH-1:0] mmio_rd_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] mmio_wr_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] stray_rsp_cnt,
  output logic [NUM_PORTS-1:0]           stray_rsp_seen
);

  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] rd_cnt;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] wr_cnt;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] stray_cnt;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ofs_plat_host_chan_tie_off_mmio_port #(
      .MMIO_RD_LATENCY (MMIO_RD_LATENCY),
      .DFH_VALUE       (DFH_VALUE),
      .MMIO_RD_DATA    (MMIO_RD_DATA),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_port (
      .clk            (clk),
      .reset_n        (reset_n),
      .ccip           (port[p]),
      .mmio_rd_cnt    (rd_cnt[p]),
      .mmio_wr_cnt    (wr_cnt[p]),
      .stray_rsp_cnt  (stray_cnt[p]),
      .stray_rsp_seen (stray_rsp_seen[p])
    );
  end

  assign mmio_rd_cnt   = rd_cnt;
  assign mmio_wr_cnt   = wr_cnt;
  assign stray_rsp_cnt = stray_cnt;

endmodule

// File: tb/tb_ofs_plat_host_chan_fiu_if_tie_off_mmio.sv
module tb_ofs_plat_host_chan_fiu_if_tie_off_mmio;
  import ofs_plat_host_chan_tie_off_pkg::*;

  localparam int          NP  = 3;
  localparam int          LAT = 4;
  localparam int          CW  = 4;
  localparam logic [63:0] DFH = 64'h1000_0100_0000_0000;
  localparam logic [63:0] RDD = 64'h0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ofs_plat_host_ccip_if ccip [NP] ();
  t_if_ccip_rx [NP-1:0] rx;
  t_if_ccip_tx [NP-1:0] tx;

  logic [NP*CW-1:0] rd_cnt_bus, wr_cnt_bus, stray_cnt_bus;
  logic [NP-1:0]    seen;

  for (genvar g = 0; g < NP; g++) begin : g_ccip
    assign ccip[g].sRx = rx[g];
    assign tx[g]       = ccip[g].sTx;
  end

  ofs_plat_host_chan_fiu_if_tie_off_mmio #(
    .NUM_PORTS       (NP),
    .MMIO_RD_LATENCY (LAT),
    .DFH_VALUE       (DFH),
    .MMIO_RD_DATA    (RDD),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .port           (ccip),
    .mmio_rd_cnt    (rd_cnt_bus),
    .mmio_wr_cnt    (wr_cnt_bus),
    .stray_rsp_cnt  (stray_cnt_bus),
    .stray_rsp_seen (seen)
  );

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } t_exp;

  t_exp exp_q [NP][$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_data(input logic [15:0] addr, input logic len8);
    logic [63:0] sel;
    sel = (addr < 16'd2) ? DFH : RDD;
    if (len8)         return sel;
    else if (addr[0]) return {32'h0, sel[63:32]};
    else              return {32'h0, sel[31:0]};
  endfunction

  function automatic logic [CW-1:0] cnt_of(input logic [NP*CW-1:0] bus, input int p);
    return bus[p*CW +: CW];
  endfunction

  // Advance to the next falling edge, score every port's outputs, then
  // return RX to idle so the caller can drive the next cycle's stimulus.
  task automatic cycle();
    t_exp e;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (tx[p].c0 !== '0 || tx[p].c1 !== '0) begin
        n_err++;
        $display("FAIL tx_idle port %0d: c0.valid=%b c1.valid=%b, want all-zero", p, tx[p].c0.valid, tx[p].c1.valid);
      end
      if (tx[p].c2.mmioRdValid === 1'b1) begin
        n_cmp++;
        if (exp_q[p].size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected port %0d cyc %0d: tid %03h, want no response", p, cyc, tx[p].c2.hdr.tid);
        end else begin
          e = exp_q[p].pop_front();
          if (tx[p].c2.hdr.tid !== e.tid || tx[p].c2.data !== e.data || cyc != e.due) begin
            n_err++;
            $display("FAIL rsp port %0d: tid %03h data %016h cyc %0d, want tid %03h data %016h cyc %0d",
                     p, tx[p].c2.hdr.tid, tx[p].c2.data, cyc, e.tid, e.data, e.due);
          end
        end
      end else if (exp_q[p].size() != 0 && cyc >= exp_q[p][0].due) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_missing port %0d cyc %0d: want tid %03h", p, cyc, exp_q[p][0].tid);
        void'(exp_q[p].pop_front());
      end
    end
    rx = '0;
  endtask

  task automatic rd(input int p, input logic [8:0] tid, input logic [15:0] addr,
                    input logic len8, input bit exp_rsp);
    t_exp e;
    rx[p].c0.mmioRdValid    = 1'b1;
    rx[p].c0.hdr.tid        = tid;
    rx[p].c0.hdr.address    = addr;
    rx[p].c0.hdr.length     = len8 ? MMIO_LEN_8B : MMIO_LEN_4B;
    if (exp_rsp) begin
      e.tid  = tid;
      e.data = exp_data(addr, len8);
      e.due  = cyc + LAT;
      exp_q[p].push_back(e);
    end
  endtask

  task automatic wr(input int p);
    rx[p].c0.mmioWrValid = 1'b1;
    rx[p].c0.data        = {8{64'hA5A5_0000_FFFF_5A5A}};
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      for (int p = 0; p < NP; p++) begin
        rd(p, 9'(i + p), 16'h0, 1'b1, 1'b0);
        wr(p);
        rx[p].c0.rspValid = 1'b1;
      end
    end
    cycle();
    reset_n = 1'b1;
    repeat (LAT + 3) cycle();
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (cnt_of(rd_cnt_bus, p) !== '0 || cnt_of(wr_cnt_bus, p) !== '0 ||
          cnt_of(stray_cnt_bus, p) !== '0 || seen[p] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_counters port %0d: rd %0d wr %0d stray %0d seen %b, want 0 0 0 0", p,
                 cnt_of(rd_cnt_bus, p), cnt_of(wr_cnt_bus, p), cnt_of(stray_cnt_bus, p), seen[p]);
      end
    end
  endtask

  task automatic test_dfh_read();
    apply_reset();
    cycle();
    rd(0, 9'h1A5, 16'h0, 1'b1, 1'b1);
    repeat (LAT) cycle();
    // Response is on the bus now but the counter only moves at its edge
    n_cmp++;
    if (cnt_of(rd_cnt_bus, 0) !== 4'd0) begin
      n_err++;
      $display("FAIL dfh_rd_cnt_early: got %0d want 0", cnt_of(rd_cnt_bus, 0));
    end
    cycle();
    n_cmp++;
    if (cnt_of(rd_cnt_bus, 0) !== 4'd1) begin
      n_err++;
      $display("FAIL dfh_rd_cnt: got %0d want 1", cnt_of(rd_cnt_bus, 0));
    end
    repeat (2) cycle();
  endtask

  task automatic test_dword_reads();
    apply_reset();
    cycle();
    rd(0, 9'h001, 16'h1, 1'b0, 1'b1);
    cycle();
    rd(0, 9'h002, 16'h2, 1'b0, 1'b1);
    repeat (LAT + 2) cycle();
    n_cmp++;
    if (cnt_of(rd_cnt_bus, 0) !== 4'd2) begin
      n_err++;
      $display("FAIL dword_rd_cnt: got %0d want 2", cnt_of(rd_cnt_bus, 0));
    end
    rd(0, 9'h003, 16'h2, 1'b1, 1'b1);
    cycle();
    rd(0, 9'h004, 16'h1, 1'b1, 1'b1);
    cycle();
    rd(0, 9'h005, 16'h3, 1'b0, 1'b1);
    repeat (LAT + 2) cycle();
    n_cmp++;
    if (cnt_of(rd_cnt_bus, 0) !== 4'd5) begin
      n_err++;
      $display("FAIL mixed_rd_cnt: got %0d want 5", cnt_of(rd_cnt_bus, 0));
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cycle();
    for (int i = 0; i < 8; i++) begin
      rd(1, 9'(i), 16'(i), 1'(i % 2), 1'b1);
      if (i == 3) wr(1);
      cycle();
    end
    repeat (LAT + 2) cycle();
    n_cmp++;
    if (cnt_of(rd_cnt_bus, 1) !== 4'd8 || cnt_of(wr_cnt_bus, 1) !== 4'd1) begin
      n_err++;
      $display("FAIL b2b_port1_cnt: rd %0d wr %0d, want rd 8 wr 1", cnt_of(rd_cnt_bus, 1), cnt_of(wr_cnt_bus, 1));
    end
    n_cmp++;
    if (cnt_of(rd_cnt_bus, 0) !== '0 || cnt_of(rd_cnt_bus, 2) !== '0 ||
        cnt_of(wr_cnt_bus, 0) !== '0 || cnt_of(wr_cnt_bus, 2) !== '0) begin
      n_err++;
      $display("FAIL b2b_other_ports: rd0 %0d rd2 %0d wr0 %0d wr2 %0d, want all 0",
               cnt_of(rd_cnt_bus, 0), cnt_of(rd_cnt_bus, 2), cnt_of(wr_cnt_bus, 0), cnt_of(wr_cnt_bus, 2));
    end
  endtask

  task automatic test_stray();
    apply_reset();
    cycle();
    rx[2].c0.rspValid = 1'b1;
    rx[2].c1.rspValid = 1'b1;
    cycle();
    n_cmp++;
    if (cnt_of(stray_cnt_bus, 2) !== 4'd2 || seen !== 3'b100) begin
      n_err++;
      $display("FAIL stray_both: cnt %0d seen %b, want cnt 2 seen 100", cnt_of(stray_cnt_bus, 2), seen);
    end
    repeat (5) cycle();
    n_cmp++;
    if (seen !== 3'b100) begin
      n_err++;
      $display("FAIL stray_sticky: seen %b want 100", seen);
    end
    rx[2].c1.rspValid = 1'b1;
    cycle();
    n_cmp++;
    if (cnt_of(stray_cnt_bus, 2) !== 4'd3 || cnt_of(stray_cnt_bus, 0) !== 4'd0) begin
      n_err++;
      $display("FAIL stray_single: cnt2 %0d cnt0 %0d, want 3 0", cnt_of(stray_cnt_bus, 2), cnt_of(stray_cnt_bus, 0));
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    cycle();
    for (int i = 1; i <= 20; i++) begin
      wr(0);
      cycle();
      if (i == 14 || i == 15) begin
        n_cmp++;
        if (cnt_of(wr_cnt_bus, 0) !== CW'(i)) begin
          n_err++;
          $display("FAIL wr_cnt_at_%0d: got %0d want %0d", i, cnt_of(wr_cnt_bus, 0), i);
        end
      end
    end
    repeat (3) cycle();
    n_cmp++;
    if (cnt_of(wr_cnt_bus, 0) !== 4'hF || cnt_of(wr_cnt_bus, 1) !== 4'h0) begin
      n_err++;
      $display("FAIL wr_cnt_sat: port0 %0d port1 %0d, want 15 0", cnt_of(wr_cnt_bus, 0), cnt_of(wr_cnt_bus, 1));
    end
    // +2 per cycle: 14 -> 15 must clamp rather than wrap to 0
    for (int i = 1; i <= 9; i++) begin
      rx[1].c0.rspValid = 1'b1;
      rx[1].c1.rspValid = 1'b1;
      cycle();
      if (i == 7 || i == 8 || i == 9) begin
        n_cmp++;
        if (cnt_of(stray_cnt_bus, 1) !== ((i == 7) ? 4'hE : 4'hF)) begin
          n_err++;
          $display("FAIL stray_sat_step_%0d: got %0d want %0d", i, cnt_of(stray_cnt_bus, 1), (i == 7) ? 14 : 15);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cycle();
    rd(0, 9'h010, 16'h0, 1'b1, 1'b1);
    rd(2, 9'h020, 16'h4, 1'b1, 1'b1);
    cycle();
    rd(0, 9'h011, 16'h1, 1'b0, 1'b1);
    repeat (LAT - 1) cycle();
    // First response on the bus; knock reset down between edges
    #1 reset_n = 1'b0;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    #1;
    n_cmp++;
    if (tx[0].c2.mmioRdValid !== 1'b0 || tx[2].c2.mmioRdValid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_valid: port0 %b port2 %b, want 0 0", tx[0].c2.mmioRdValid, tx[2].c2.mmioRdValid);
    end
    cycle();
    cycle();
    reset_n = 1'b1;
    rd(0, 9'h0AA, 16'h0, 1'b1, 1'b1);
    repeat (LAT + 4) cycle();
    n_cmp++;
    if (cnt_of(rd_cnt_bus, 0) !== 4'd1 || cnt_of(rd_cnt_bus, 2) !== 4'd0) begin
      n_err++;
      $display("FAIL reset_mid_cnt: rd0 %0d rd2 %0d, want 1 0", cnt_of(rd_cnt_bus, 0), cnt_of(rd_cnt_bus, 2));
    end
  endtask

  initial begin
    rx = '0;
    test_reset();
    test_dfh_read();
    test_dword_reads();
    test_back_to_back();
    test_stray();
    test_saturation();
    test_reset_mid();
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (exp_q[p].size() != 0) begin
        n_err++;
        $display("FAIL drain port %0d: %0d responses outstanding, want 0", p, exp_q[p].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
